// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory-stage access unit.
//   - FSM state encoding (2-bit)
//   - default byte address of data-memory word 0
//   - value returned to MEM/WB when an access is aborted or is a store
package mem_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_WAIT = 2'd1;
  localparam state_t S_DONE = 2'd2;

  localparam logic [31:0] DATA_BASE_DEF = 32'h1001_0000;
  localparam logic [31:0] ABORT_RDATA   = 32'h0;

endpackage

// File: rtl/mem_wait_counter.sv
// mem_wait_counter: saturating up-counter used as the memory timeout.
// Ports:
//   clk, reset  - falling-edge clock, async active-low reset
//   i_clr       - synchronous clear to 0 (has priority over i_en)
//   i_en        - count up by one, holding at MAX_WAIT
//   o_done      - count has reached MAX_WAIT
module mem_wait_counter #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_done
);

  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [CW-1:0] r_cnt;
  logic          w_sat;

  assign w_sat  = (r_cnt >= CW'(MAX_WAIT));
  assign o_done = w_sat;

  always_ff @(negedge clk or negedge reset) begin
    if (!reset)                r_cnt <= '0;
    else if (i_clr)            r_cnt <= '0;
    else if (i_en && !w_sat)   r_cnt <= r_cnt + CW'(1);
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage controller. Turns the EX/MEM load/store into a
// req/ack transaction on the data-memory port and stalls the front of the
// pipeline while it is outstanding.
// Ports:
//   clk, reset                 - falling-edge clock, async active-low reset
//   MemRead/MemWrite_EX_MEM    - access request (both set = store)
//   ALUResult_EX_MEM           - byte address; WriteData_EX_MEM - store data
//   mem_rdata, mem_ack         - memory response (ack is a one-cycle pulse)
//   mem_req/we/addr/wdata      - registered memory request
//   ReadMemData                - load result to MEM/WB
//   Stall_MEM, Enable_MEM_WB   - pipeline freeze / MEM/WB capture enable
//   AddrError, BusError        - sticky error flags, cleared by reset only
module mem_access_unit
  import mem_pkg::*;
#(
  parameter logic [31:0] DATA_BASE  = DATA_BASE_DEF,
  parameter int          ADDR_WIDTH = 10,
  parameter int          MAX_WAIT   = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemRead_EX_MEM,
  input  logic                  MemWrite_EX_MEM,
  input  logic [31:0]           ALUResult_EX_MEM,
  input  logic [31:0]           WriteData_EX_MEM,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ack,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [31:0]           ReadMemData,
  output logic                  Stall_MEM,
  output logic                  Enable_MEM_WB,
  output logic                  AddrError,
  output logic                  BusError
);

  state_t                r_state, w_next;
  logic                  r_req, r_we, r_addr_err, r_bus_err;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata, r_rdata;

  logic                  w_access, w_bad, w_go;
  logic [31:0]           w_off;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic                  w_stall, w_cnt_clr, w_cnt_en, w_cnt_done;

  assign w_access = MemRead_EX_MEM | MemWrite_EX_MEM;
  assign w_bad    = (ALUResult_EX_MEM[1:0] != 2'b00) || (ALUResult_EX_MEM < DATA_BASE);
  assign w_go     = w_access && !w_bad;
  assign w_off    = ALUResult_EX_MEM - DATA_BASE;
  // Word address wraps modulo the memory size.
  assign w_waddr  = ADDR_WIDTH'(w_off >> 2);

  mem_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_cnt_clr),
    .i_en   (w_cnt_en),
    .o_done (w_cnt_done)
  );

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_stall   = 1'b0;
    w_cnt_clr = 1'b0;
    w_cnt_en  = 1'b0;
    case (r_state)
      S_IDLE: if (w_go) begin
        w_next    = S_WAIT;
        w_stall   = 1'b1;
        w_cnt_clr = 1'b1;
      end
      S_WAIT: begin
        w_stall = 1'b1;
        // Ack beats a simultaneous timeout.
        if (mem_ack || w_cnt_done) w_next = S_DONE;
        else                       w_cnt_en = 1'b1;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_addr_err <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_access && w_bad) r_addr_err <= 1'b1;
          else if (w_go) begin
            r_req   <= 1'b1;
            r_we    <= MemWrite_EX_MEM;
            r_addr  <= w_waddr;
            r_wdata <= WriteData_EX_MEM;
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            r_rdata <= r_we ? ABORT_RDATA : mem_rdata;
            r_req   <= 1'b0;
          end else if (w_cnt_done) begin
            r_bus_err <= 1'b1;
            r_rdata   <= ABORT_RDATA;
            r_req     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req       = r_req;
  assign mem_we        = r_we;
  assign mem_addr      = r_addr;
  assign mem_wdata     = r_wdata;
  assign ReadMemData   = (r_state == S_DONE) ? r_rdata : ABORT_RDATA;
  assign Stall_MEM     = w_stall;
  assign Enable_MEM_WB = ~w_stall;
  assign AddrError     = r_addr_err;
  assign BusError      = r_bus_err;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam int MAXW = 15;

  logic        clk, reset;
  logic        MemRead_EX_MEM, MemWrite_EX_MEM;
  logic [31:0] ALUResult_EX_MEM, WriteData_EX_MEM;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        mem_req, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, ReadMemData;
  logic        Stall_MEM, Enable_MEM_WB, AddrError, BusError;

  mem_access_unit #(.DATA_BASE(BASE), .ADDR_WIDTH(10), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset),
    .MemRead_EX_MEM(MemRead_EX_MEM), .MemWrite_EX_MEM(MemWrite_EX_MEM),
    .ALUResult_EX_MEM(ALUResult_EX_MEM), .WriteData_EX_MEM(WriteData_EX_MEM),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .ReadMemData(ReadMemData), .Stall_MEM(Stall_MEM), .Enable_MEM_WB(Enable_MEM_WB),
    .AddrError(AddrError), .BusError(BusError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory environment: acks lat_cfg cycles after mem_req rises (0 = never).
  logic [31:0] sim_mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  int lat_cfg = 1;
  logic stray = 1'b0;

  initial begin
    int rcnt;
    logic acked;
    rcnt = 0; acked = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk);
      mem_ack = stray;
      if (mem_req && !acked) begin
        rcnt++;
        if (lat_cfg != 0 && rcnt == lat_cfg) begin
          mem_ack   = 1'b1;
          acked     = 1'b1;
          mem_rdata = sim_mem[mem_addr];
          if (mem_we) sim_mem[mem_addr] = mem_wdata;
        end
      end else if (!mem_req) begin
        rcnt = 0; acked = 1'b0;
      end
    end
  end

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, wdata;
    int          lat;
    int          stall;
    logic [31:0] rdata;
    logic        we;
    logic [9:0]  waddr;
    logic        ae, be;
  } vec_t;

  // Drive one access from the start of a cycle and follow it through MEM.
  task automatic run(input string tag, input vec_t v);
    int n;
    @(posedge clk);
    lat_cfg = v.lat;
    MemRead_EX_MEM = v.rd; MemWrite_EX_MEM = v.wr;
    ALUResult_EX_MEM = v.addr; WriteData_EX_MEM = v.wdata;
    #1;
    n = 0;
    while (Stall_MEM && n < 60) begin
      n++;
      @(posedge clk); #1;
      if (n == 1 && Stall_MEM) begin
        chk({tag, ".req"}, {31'd0, mem_req}, 32'd1);
        chk({tag, ".we"}, {31'd0, mem_we}, {31'd0, v.we});
        chk({tag, ".addr"}, {22'd0, mem_addr}, {22'd0, v.waddr});
        if (v.wr) chk({tag, ".wdata"}, mem_wdata, v.wdata);
      end
    end
    chk({tag, ".stall"}, n, v.stall);
    chk({tag, ".en"}, {31'd0, Enable_MEM_WB}, 32'd1);
    if (v.rd || v.wr) chk({tag, ".rdata"}, ReadMemData, v.rdata);
    @(negedge clk); #1;
    chk({tag, ".ae"}, {31'd0, AddrError}, {31'd0, v.ae});
    chk({tag, ".be"}, {31'd0, BusError}, {31'd0, v.be});
    chk({tag, ".reqoff"}, {31'd0, mem_req}, 32'd0);
    MemRead_EX_MEM = 1'b0; MemWrite_EX_MEM = 1'b0;
  endtask

  vec_t tbl [11];

  initial begin
    vec_t v;
    logic ref_ae, ref_be;
    for (int i = 0; i < 1024; i++) sim_mem[i] = $urandom;
    sim_mem[2] = 32'hCAFE_0001;

    tbl[0]  = '{1'b1, 1'b0, 32'h1001_0008, 32'h0, 2, 3, 32'hCAFE_0001, 1'b0, 10'd2, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 32'h1001_0004, 32'h1234_5678, 1, 2, 32'h0, 1'b1, 10'd1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 32'h1001_0004, 32'h0, 1, 2, 32'h1234_5678, 1'b0, 10'd1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 32'h1001_0006, 32'h0, 1, 0, 32'h0, 1'b0, 10'd0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 32'h1001_0008, 32'h0, 3, 4, 32'hCAFE_0001, 1'b0, 10'd2, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 32'h1000_FFFC, 32'h0, 1, 0, 32'h0, 1'b0, 10'd0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 32'h1001_000C, 32'hAABB_CCDD, 1, 2, 32'h0, 1'b1, 10'd3, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 32'h1001_000C, 32'h0, 16, 17, 32'hAABB_CCDD, 1'b0, 10'd3, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 32'h1001_0010, 32'h0, 0, 17, 32'h0, 1'b0, 10'd4, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 32'h1001_1008, 32'h0, 1, 2, 32'hCAFE_0001, 1'b0, 10'd2, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 32'h1001_0020, 32'h0, 1, 0, 32'h0, 1'b0, 10'd0, 1'b1, 1'b1};

    reset = 1'b0;
    MemRead_EX_MEM = 1'b0; MemWrite_EX_MEM = 1'b0;
    ALUResult_EX_MEM = '0; WriteData_EX_MEM = '0;
    #1;
    chk("rst.stall", {31'd0, Stall_MEM}, 32'd0);
    chk("rst.en", {31'd0, Enable_MEM_WB}, 32'd1);
    chk("rst.req", {31'd0, mem_req}, 32'd0);
    chk("rst.ae", {31'd0, AddrError}, 32'd0);
    chk("rst.be", {31'd0, BusError}, 32'd0);
    chk("rst.addr", {22'd0, mem_addr}, 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;

    for (int i = 0; i < 11; i++) run($sformatf("tbl%0d", i), tbl[i]);

    // Ack pulse while idle must not disturb the FSM.
    @(posedge clk); stray = 1'b1;
    @(posedge clk); stray = 1'b0; #1;
    chk("stray.stall", {31'd0, Stall_MEM}, 32'd0);
    chk("stray.req", {31'd0, mem_req}, 32'd0);
    v = '{1'b1, 1'b0, 32'h1001_0008, 32'h0, 2, 3, 32'hCAFE_0001, 1'b0, 10'd2, 1'b1, 1'b1};
    run("after_stray", v);

    // Randomised accesses against a reference model.
    for (int i = 0; i < 1024; i++) ref_mem[i] = sim_mem[i];
    ref_ae = 1'b1; ref_be = 1'b1;
    for (int t = 0; t < 40; t++) begin
      int kind, r;
      logic [9:0] wa;
      kind = int'($urandom_range(0, 5));
      r    = int'($urandom_range(0, 9));
      v.lat   = (r == 0) ? 0 : (r == 1) ? 16 : (r == 2) ? 17 : r - 2;
      v.rd    = (kind == 1 || kind == 2 || kind == 3 || kind == 5);
      v.wr    = (kind == 4 || kind == 5);
      v.wdata = $urandom;
      if (kind == 1)      v.addr = BASE + 4 * $urandom_range(0, 2047) + $urandom_range(1, 3);
      else if (kind == 2) v.addr = $urandom_range(0, BASE - 1) & 32'hFFFF_FFFC;
      else                v.addr = BASE + 4 * $urandom_range(0, 2047);
      wa = 10'((v.addr - BASE) / 4);
      v.we = v.wr; v.waddr = wa; v.rdata = 32'h0; v.stall = 0;
      if ((v.rd || v.wr) && (v.addr % 4 != 0 || v.addr < BASE)) begin
        ref_ae = 1'b1;
      end else if (v.rd || v.wr) begin
        if (v.lat != 0 && v.lat <= MAXW + 1) begin
          v.stall = v.lat + 1;
          if (v.wr) ref_mem[wa] = v.wdata;
          else      v.rdata = ref_mem[wa];
        end else begin
          v.stall = MAXW + 2;
          ref_be  = 1'b1;
        end
      end
      v.ae = ref_ae; v.be = ref_be;
      run($sformatf("rnd%0d", t), v);
    end

    // Reset in the middle of WAIT.
    @(posedge clk);
    lat_cfg = 0;
    MemRead_EX_MEM = 1'b1; ALUResult_EX_MEM = BASE + 32'h20;
    repeat (3) @(posedge clk);
    #1;
    chk("mid.stall", {31'd0, Stall_MEM}, 32'd1);
    chk("mid.req", {31'd0, mem_req}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid.reqdrop", {31'd0, mem_req}, 32'd0);
    chk("mid.ae", {31'd0, AddrError}, 32'd0);
    chk("mid.be", {31'd0, BusError}, 32'd0);
    MemRead_EX_MEM = 1'b0;
    #1;
    chk("mid.idle", {31'd0, Stall_MEM}, 32'd0);
    @(posedge clk); #2 reset = 1'b1;
    v = '{1'b1, 1'b0, 32'h1001_0008, 32'h0, 1, 2, ref_mem[2], 1'b0, 10'd2, 1'b0, 1'b0};
    run("post_rst", v);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
